// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single data-memory port between two requesters:
//   requester 0 = CPU M-stage, requester 1 = DMA/debug port.
// One access is in flight at a time. Stores are lane-steered and given byte
// enables. Misaligned or illegal-size accesses are not issued to memory; they
// complete with an error response instead. Loads return the raw memory word,
// and the requester extends the byte or halfword itself.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   reqN/weN/sizeN/addrN/wdataN   requester N access (N = 0,1), held until gntN
//   gntN                    combinational grant, asserted only in IDLE
//   respN/errN/rdataN       registered completion pulse, error flag, raw load word
//   mem_en/mem_be/mem_addr/mem_wdata   memory port strobe, byte enables, word address, data
//   mem_rdata               synchronous read data, valid the cycle after mem_en
//
// Build option:
//   DM_ARB_FIXED_PRIO_EN    when defined, requester 0 always wins a tie
//                           (requester 1 may starve); otherwise round-robin.

module dm_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        size0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              resp0,
  output logic              resp1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, next_state;

  // Latched access, captured at grant.
  logic              owner;
  logic              cur_we;
  logic              cur_illegal;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic              prefer1;
  logic              pick1;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              issue_ok;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == 2'b10 && lo != 2'b00) || (size == 2'b01 && lo[0]);
  endfunction

  function automatic logic [3:0] steer_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

`ifdef DM_ARB_FIXED_PRIO_EN
  // Debug builds: requester 0 wins every tie, no fairness history kept.
  assign prefer1 = 1'b0;
`else
  // rr_last remembers the requester granted most recently; the other one wins
  // a tie. It resets to 1 so requester 0 gets the first tie.
  logic rr_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_last <= 1'b1;
    else if (gnt0 || gnt1)
      rr_last <= gnt1;
  end

  assign prefer1 = ~rr_last;
`endif

  // A lone requester always wins; requester 1 wins a tie only when preferred.
  assign pick1     = req1 && (!req0 || prefer1);
  assign sel_we    = pick1 ? we1    : we0;
  assign sel_size  = pick1 ? size1  : size0;
  assign sel_addr  = pick1 ? addr1  : addr0;
  assign sel_wdata = pick1 ? wdata1 : wdata0;

  // Next state and grants. Grants are gated by reset so nothing is accepted
  // while the block is being cleared.
  always_comb begin
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (req0 || req1)) begin
          gnt0       = !pick1;
          gnt1       = pick1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = (!cur_illegal && !cur_we) ? WAIT : IDLE;
      WAIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Capture the winning access. The address and data registers also drive
  // mem_addr/mem_wdata, so they hold their value between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      cur_we      <= 1'b0;
      cur_illegal <= 1'b0;
      cur_size    <= 2'b00;
      cur_addr    <= '0;
      cur_wdata   <= '0;
    end else if (gnt0 || gnt1) begin
      owner       <= pick1;
      cur_we      <= sel_we;
      cur_illegal <= is_illegal(sel_size, sel_addr[1:0]);
      cur_size    <= sel_size;
      cur_addr    <= sel_addr;
      cur_wdata   <= sel_wdata;
    end
  end

  assign issue_ok  = (state == ISSUE) && !cur_illegal;
  assign mem_en    = issue_ok;
  assign mem_be    = (issue_ok && cur_we) ? steer_be(cur_size, cur_addr[1:0]) : 4'b0000;
  assign mem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = steer_wdata(cur_size, cur_wdata);

  // Completion: stores and rejected accesses finish from ISSUE, loads from WAIT
  // where the synchronous read data is captured. rdataN only changes on loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp0  <= 1'b0;
      resp1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      resp0 <= 1'b0;
      resp1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        ISSUE: begin
          if (cur_illegal || cur_we) begin
            if (owner) begin
              resp1 <= 1'b1;
              err1  <= cur_illegal;
            end else begin
              resp0 <= 1'b1;
              err0  <= cur_illegal;
            end
          end
        end
        WAIT: begin
          if (owner) begin
            resp1  <= 1'b1;
            rdata1 <= mem_rdata;
          end else begin
            resp0  <= 1'b1;
            rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
